hand_reg_bank: RTL
==================

Name: hand_reg_bank

Overview:
Parametrised successor to the single-card load registers. It holds an entire baccarat hand of up to NUM_CARDS cards in one block and appends each card into the next free slot. It also keeps a running baccarat score, a card count, and full, overflow and bad-card status. One instance serves the player hand and one serves the dealer hand; both are driven by the round-control FSM and the card dealer.

Parameters:
NUM_CARDS, 3, maximum cards per hand (legal range 2..8).
CARD_W, 4, card code width; codes 1..13 = A..K (legal range >=4).

Ports:
slow_clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset; clears all state.
new_card  input  CARD_W  card code from the dealer.
load_card  input  1  append new_card this cycle.
clear_hand  input  1  synchronous hand clear for a new round.
cards  output  NUM_CARDS*CARD_W  slot k at bits [k*CARD_W +: CARD_W]; slot 0 = first card dealt.
card_count  output  CNT_W  cards held; CNT_W = $clog2(NUM_CARDS+1).
hand_full  output  1  card_count == NUM_CARDS.
score  output  4  (sum of card values) mod 10.
card_loaded  output  1  one-cycle pulse: a card was stored on the previous edge.
overflow  output  1  sticky: load attempted while full.
bad_card  output  1  sticky: load attempted with an illegal code.

Behaviour:
- Reset is asynchronous: cards, card_count, score, card_loaded, overflow, bad_card and hand_full all go to 0 immediately and stay 0 while reset is high.
- Card value rules:
  - code 1..9 -> value equals the code.
  - code 10..13 -> value 0.
  - code 0 or code >13 -> illegal.
- Accepted load: load_card=1, clear_hand=0, hand not full, legal code. On that edge:
  - cards[card_count] <= new_card.
  - card_count increments by 1.
  - score <= (score + value) mod 10, computed with a 5-bit intermediate.
  - card_loaded = 1 for exactly that following cycle.
  - Latency from load to all updated outputs: 1 edge.
- Load while full: nothing is stored; card_count and score hold; overflow sets. card_loaded stays 0.
- Load with an illegal code: nothing is stored; bad_card sets. If the hand is also full, overflow sets too.
- clear_hand=1: on the edge, all slots, card_count, score, overflow and bad_card go to 0.
  - clear_hand has priority over load_card; a simultaneous load is dropped and does not set any flag.
- Slots never wrap; the write pointer equals card_count. Slots at or above card_count read 0.
- hand_full is combinational from card_count.
- New values on new_card while load_card=0 are ignored.
- Asserting reset mid-hand discards all cards. The first load after reset deasserts goes into slot 0.
- Sticky flags clear only on reset or clear_hand.

Optional Feature:
Macro HAND_NATURAL_EN.
- Defined: adds output port natural (1 bit). natural=1 when card_count == 2 and score is 8 or 9. It is registered and updates on the same edge as score. It clears on reset or clear_hand, and drops to 0 once a third card is accepted.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package baccarat_pkg:
  - constants CARD_MIN=1, CARD_MAX=13 and FACE_MIN=10.
  - function card_value(code) -> 4-bit value.
  - function mod10_add(a, b) -> 4-bit result.
- Sub-module card_slot_reg: one CARD_W register with load enable and sync clear, instantiated NUM_CARDS times in a generate loop. Write enable for slot k is accepted_load && card_count==k.
- Counter, score accumulator and flag logic stay in the top module.

Test Plan:
- Reset release, then load 7 and 8 on consecutive cycles -> cards slot0=7, slot1=8; card_count=2; score=5; card_loaded pulses once per load; with HAND_NATURAL_EN, natural=0.
- Load 9, then 13 -> score=9, card_count=2; with HAND_NATURAL_EN, natural=1. Load 4 next -> score=3, card_count=3, hand_full=1, natural=0.
- Full hand of 3 cards, then load 5 -> cards, count and score unchanged; overflow=1; card_loaded=0.
- Load codes 0 and 14 into an empty hand -> card_count=0, score=0, bad_card=1. Next load 2 -> stored in slot 0, score=2.
- clear_hand and load_card with card 6 in the same cycle, hand holding 2 cards -> card_count=0, score=0, all slots 0, no flags set.
- Assert reset mid-cycle with 2 cards held -> outputs read 0 before the next clock edge. After release, load 3 -> slot0=3, count=1, score=3.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared baccarat card helpers: legal code range, card value lookup and
// modulo-10 score accumulation.
package baccarat_pkg;

    localparam int unsigned CARD_MIN = 1;
    localparam int unsigned CARD_MAX = 13;
    localparam int unsigned FACE_MIN = 10;

    function automatic logic card_legal(input logic [31:0] code);
        return (code >= CARD_MIN) && (code <= CARD_MAX);
    endfunction

    // Tens and face cards count zero; illegal codes also map to zero so the
    // caller can gate on card_legal separately.
    function automatic logic [3:0] card_value(input logic [31:0] code);
        logic [3:0] val;
        val = 4'd0;
        if (card_legal(code) && (code < FACE_MIN))
            val = code[3:0];
        return val;
    endfunction

    function automatic logic [3:0] mod10_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

endpackage

// File: rtl/card_slot_reg.sv
// One card slot: CARD_W register with load enable and synchronous clear.
module card_slot_reg #(
    parameter int CARD_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CARD_W-1:0] card_i,
    output logic [CARD_W-1:0] card_o
);

    logic [CARD_W-1:0] card_q;
    logic [CARD_W-1:0] card_d;

    always_comb begin
        card_d = card_q;
        if (clr_i)
            card_d = '0;
        else if (load_i)
            card_d = card_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            card_q <= '0;
        else
            card_q <= card_d;
    end

    assign card_o = card_q;

endmodule

// File: rtl/hand_reg_bank.sv
// Baccarat hand register bank: appends cards into slots, keeps count, score
// and sticky status. Optional `natural` output under macro HAND_NATURAL_EN.
module hand_reg_bank
    import baccarat_pkg::*;
#(
    parameter int NUM_CARDS = 3,
    parameter int CARD_W    = 4,
    localparam int CNT_W    = $clog2(NUM_CARDS + 1)
) (
    input  logic                        slow_clock,
    input  logic                        reset,
    input  logic [CARD_W-1:0]           new_card,
    input  logic                        load_card,
    input  logic                        clear_hand,
    output logic [NUM_CARDS*CARD_W-1:0] cards,
    output logic [CNT_W-1:0]            card_count,
    output logic                        hand_full,
    output logic [3:0]                  score,
    output logic                        card_loaded,
    output logic                        overflow,
    output logic                        bad_card
`ifdef HAND_NATURAL_EN
    ,
    output logic                        natural
`endif
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       score_q, score_d;
    logic             loaded_q, loaded_d;
    logic             overflow_q, overflow_d;
    logic             bad_q, bad_d;

    logic             full;
    logic             legal;
    logic             load_live;
    logic             accepted_load;
    logic [3:0]       value;

    assign full          = (count_q == CNT_W'(NUM_CARDS));
    assign legal         = card_legal(32'(new_card));
    assign value         = card_value(32'(new_card));
    // A load coinciding with clear_hand is dropped entirely, flags included.
    assign load_live     = load_card && !clear_hand;
    assign accepted_load = load_live && !full && legal;

    always_comb begin
        count_d    = count_q;
        score_d    = score_q;
        loaded_d   = 1'b0;
        overflow_d = overflow_q;
        bad_d      = bad_q;
        if (clear_hand) begin
            count_d    = '0;
            score_d    = 4'd0;
            overflow_d = 1'b0;
            bad_d      = 1'b0;
        end else begin
            if (accepted_load) begin
                count_d  = count_q + CNT_W'(1);
                score_d  = mod10_add(score_q, value);
                loaded_d = 1'b1;
            end
            if (load_live && full)
                overflow_d = 1'b1;
            if (load_live && !legal)
                bad_d = 1'b1;
        end
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            score_q    <= 4'd0;
            loaded_q   <= 1'b0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            score_q    <= score_d;
            loaded_q   <= loaded_d;
            overflow_q <= overflow_d;
            bad_q      <= bad_d;
        end
    end

    // Write pointer is the card count, so slots fill strictly in deal order.
    for (genvar k = 0; k < NUM_CARDS; k++) begin : g_slot
        card_slot_reg #(
            .CARD_W (CARD_W)
        ) u_slot (
            .clk_i  (slow_clock),
            .rst_i  (reset),
            .load_i (accepted_load && (count_q == CNT_W'(k))),
            .clr_i  (clear_hand),
            .card_i (new_card),
            .card_o (cards[k*CARD_W +: CARD_W])
        );
    end

`ifdef HAND_NATURAL_EN
    logic natural_q, natural_d;

    always_comb begin
        natural_d = natural_q;
        if (clear_hand)
            natural_d = 1'b0;
        else if (accepted_load)
            natural_d = (count_q == CNT_W'(1)) && (score_d >= 4'd8);
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset)
            natural_q <= 1'b0;
        else
            natural_q <= natural_d;
    end

    assign natural = natural_q;
`endif

    assign card_count  = count_q;
    assign hand_full   = full;
    assign score       = score_q;
    assign card_loaded = loaded_q;
    assign overflow    = overflow_q;
    assign bad_card    = bad_q;

endmodule
